// File: rtl/fcs_mpc_pkg.sv
// rtl/fcs_mpc_pkg.sv - shared state encoding, cost width and saturation helper for the FCS-MPC controller
package fcs_mpc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_EVAL   = 2'd2,
        ST_APPLY  = 2'd3
    } state_e;

    // Cost carries two guard bits above the sample width so |error| plus penalty rarely clips
    localparam int COST_GUARD = 2;

    function automatic int cost_width(input int w);
        return w + COST_GUARD;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^w-1]
    function automatic logic [31:0] sat_u(input logic signed [31:0] v, input int w);
        logic signed [32:0] hi;
        hi = (33'sd1 <<< w) - 33'sd1;
        if (v < 0) begin
            return 32'd0;
        end
        if ($signed({v[31], v}) > hi) begin
            return hi[31:0];
        end
        return v;
    endfunction

endpackage

// File: rtl/fcs_mpc_predict.sv
// rtl/fcs_mpc_predict.sv - one-candidate current prediction and switching cost
module fcs_mpc_predict
    import fcs_mpc_pkg::*;
#(
    parameter int W      = 8,
    parameter int KA     = 4,
    parameter int SHIFT  = 4,
    parameter int LAMBDA = 2
) (
    input  logic [W-1:0]                il_k_i,
    input  logic [W-1:0]                vg_i,
    input  logic [W-1:0]                vc_i,
    input  logic [W-1:0]                iref_i,
    input  logic                        c_i,
    input  logic                        u_k_i,
    output logic [cost_width(W)-1:0]    cost_o
);

    localparam int CW = cost_width(W);
    localparam int PW = W + 8;
    localparam logic signed [PW-1:0] KA_S = PW'(KA);

    logic [W-1:0]          vg_sel;
    logic signed [W:0]     d;
    logic signed [PW-1:0]  d_ext;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  p;
    logic [W-1:0]          p_sat;
    logic [W-1:0]          err;
    logic [31:0]           pen;

    // Inductor slope for the candidate, scaled prediction, clamp, then tracking error plus switching penalty
    always_comb begin
        vg_sel = c_i ? vg_i : {W{1'b0}};
        d      = $signed({1'b0, vg_sel}) - $signed({1'b0, vc_i});
        d_ext  = {{(PW-W-1){d[W]}}, d};
        prod   = d_ext * KA_S;
        p      = $signed({8'b0, il_k_i}) + (prod >>> SHIFT);
        p_sat  = W'(sat_u(32'(p), W));
        err    = (iref_i >= p_sat) ? (iref_i - p_sat) : (p_sat - iref_i);
        pen    = (c_i != u_k_i) ? 32'(LAMBDA) : 32'd0;
        cost_o = CW'(sat_u($signed(32'(err) + pen), CW));
    end

endmodule

// File: rtl/fcs_mpc_multi.sv
// rtl/fcs_mpc_multi.sv - interleaved multi-channel finite-control-set MPC with a time-shared predictor
module fcs_mpc_multi
    import fcs_mpc_pkg::*;
#(
    parameter int W      = 8,
    parameter int N_CH   = 2,
    parameter int KA     = 4,
    parameter int SHIFT  = 4,
    parameter int LAMBDA = 2,
    parameter int PERIOD = 100
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                en,
    input  logic [W-1:0]        iref,
    input  logic [N_CH*W-1:0]   il,
    input  logic [W-1:0]        vg,
    input  logic [W-1:0]        vc,
    output logic [N_CH-1:0]     u,
    output logic [N_CH-1:0]     oeb,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    localparam int CW    = cost_width(W);
    localparam int NE    = 2 * N_CH;
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;

    if (PERIOD < 2 * N_CH + 3) begin : g_period_check
        $error("fcs_mpc_multi: PERIOD must be at least 2*N_CH+3");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_CH*W-1:0]   il_q;
    logic [W-1:0]        vg_q, vc_q, iref_q;
    logic [N_CH-1:0]     u_q, best_q, best_d;
    logic [CW-1:0]       cost0_q, cost_cur;
    logic                overrun_q;
    logic                tick;
    logic                cand;
    logic                dec;
    logic                last_eval;
    int                  ch;

    assign tick      = en && (cnt_q == CNT_W'(PERIOD - 1));
    assign cand      = idx_q[0];
    assign last_eval = (state_q == ST_EVAL) && (idx_q == IDX_W'(NE - 1));

    assign u       = u_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_APPLY);
    assign overrun = overrun_q;
    assign oeb     = (en && !wb_rst_i) ? {N_CH{1'b0}} : {N_CH{1'b1}};

    // Free-running control-period counter, parked at zero while disabled
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (!en || cnt_q == CNT_W'(PERIOD - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sequencing: disable aborts from any state and takes priority over a tick
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE:   if (tick) state_d = ST_SAMPLE;
                ST_SAMPLE: begin
                    state_d = ST_EVAL;
                    idx_d   = '0;
                end
                ST_EVAL: begin
                    if (idx_q == IDX_W'(NE - 1)) begin
                        state_d = ST_APPLY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_APPLY:  state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State and evaluation-index registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    fcs_mpc_predict #(
        .W      (W),
        .KA     (KA),
        .SHIFT  (SHIFT),
        .LAMBDA (LAMBDA)
    ) u_predict (
        .il_k_i (il_q[ch*W +: W]),
        .vg_i   (vg_q),
        .vc_i   (vc_q),
        .iref_i (iref_q),
        .c_i    (cand),
        .u_k_i  (u_q[ch]),
        .cost_o (cost_cur)
    );

    // Pick the cheaper candidate for the channel under evaluation; ties keep the present switch state
    always_comb begin
        ch     = int'(idx_q >> 1);
        best_d = best_q;
        dec    = u_q[ch];
        if (cost_cur < cost0_q) begin
            dec = 1'b1;
        end else if (cost0_q < cost_cur) begin
            dec = 1'b0;
        end
        if (state_q == ST_EVAL && cand) begin
            best_d[ch] = dec;
        end
    end

    // Snapshot of the measurements and the per-channel running decision
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            il_q    <= '0;
            vg_q    <= '0;
            vc_q    <= '0;
            iref_q  <= '0;
            cost0_q <= '0;
            best_q  <= '0;
        end else if (en) begin
            if (state_q == ST_SAMPLE) begin
                il_q   <= il;
                vg_q   <= vg;
                vc_q   <= vc;
                iref_q <= iref;
            end
            if (state_q == ST_EVAL && !cand) begin
                cost0_q <= cost_cur;
            end
            best_q <= best_d;
        end
    end

    // Gate commands update together on entry to APPLY; overrun is sticky until disable
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            u_q       <= '0;
            overrun_q <= 1'b0;
        end else if (!en) begin
            u_q       <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (last_eval) begin
                u_q <= best_d;
            end
            if (tick && state_q != ST_IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule
